// File: rtl/accel_issue_pkg.sv
// accel_issue shared types: FSM states, bus widths and the sticky-interrupt merge.
// Included by every accel_issue RTL file through import accel_issue_pkg::*.
package accel_issue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IRQ_W   = 19;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  // A set in the same cycle as a clear of that bit leaves the bit set.
  function automatic logic [IRQ_W-1:0] irq_merge(
    input logic [IRQ_W-1:0] vec,
    input logic [IRQ_W-1:0] clr,
    input logic [IRQ_W-1:0] set
  );
    return (vec & ~clr) | set;
  endfunction

endpackage

// File: rtl/accel_issue_fifo.sv
// Synchronous FIFO for accel_issue: power-of-2 DEPTH, full/empty flags,
// simultaneous push and pop both honoured, no bypass from din to dout.
module accel_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/accel_issue.sv
// Command issuer in front of Accel: FIFO, reset-pulse sequencing, holdoff, irqs.
// Optional RUN watchdog enabled by defining ACCEL_ISSUE_TIMEOUT_EN.
module accel_issue
  import accel_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned HOLDOFF = 10,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_ext,
  input  logic [INSTR_W-1:0] cpu_instr,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic               accel_rst,
  input  logic [IRQ_W-1:0]   accel_interrupt,
  input  logic               accel_done,
  input  logic [IRQ_W-1:0]   irq_clr,
  output logic [IRQ_W-1:0]   irq_vec,
  output logic               irq,
  output logic               busy,
  output logic               cmd_done,
  output logic [CNT_W-1:0]   cmd_count,
  output logic               timeout
);

  localparam int unsigned HO_W = $clog2(HOLDOFF + 1);

  state_t             state;
  state_t             state_nx;
  logic               f_full;
  logic               f_empty;
  logic [INSTR_W-1:0] f_data;
  logic               pop;
  logic               ld_hold;
  logic               fin;
  logic               wd_hit;
  logic               active;
  logic [HO_W-1:0]    hold_q;
  logic [IRQ_W-1:0]   irq_nx;

  assign cpu_ready = !f_full && !rst_ext;
  assign busy      = state != IDLE;
  assign active    = (state == RUN) || (state == DRAIN);

  accel_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_ext),
    .push  (cpu_valid && cpu_ready),
    .din   (cpu_instr),
    .pop   (pop),
    .dout  (f_data),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    ld_hold   = 1'b0;
    fin       = 1'b0;
    accel_rst = 1'b1;
    unique case (state)
      IDLE: begin
        if (!f_empty) begin
          pop      = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        accel_rst = 1'b0;
        if (accel_done) begin
          ld_hold  = 1'b1;
          state_nx = DRAIN;
        end else if (wd_hit) begin
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        accel_rst = 1'b0;
        if (hold_q == '0) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // accel_done leads the last result, so completion waits HOLDOFF cycles.
  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      hold_q <= '0;
    end else if (ld_hold) begin
      hold_q <= HO_W'(HOLDOFF - 1);
    end else if (state == DRAIN && hold_q != '0) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  assign irq_nx = irq_merge(irq_vec, irq_clr,
                            accel_interrupt & {IRQ_W{active}});

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      instruction <= '0;
      irq_vec     <= '0;
      irq         <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_count   <= '0;
    end else begin
      if (pop) instruction <= f_data;
      irq_vec  <= irq_nx;
      irq      <= |irq_nx;
      cmd_done <= fin;
      if (fin) cmd_count <= cmd_count + 1'b1;
    end
  end

`ifdef ACCEL_ISSUE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            to_q;

  assign wd_hit  = wd_q == WD_W'(TIMEOUT - 1);
  assign timeout = to_q;

  // Counter is held at zero outside RUN, so every RUN entry starts fresh.
  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (state != RUN) wd_q <= '0;
      else              wd_q <= wd_q + 1'b1;
      if (state == RUN && !accel_done && wd_hit) to_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign wd_hit         = 1'b0;
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_accel_issue.sv
// Directed bench for accel_issue: stimulus queues expected completions,
// a negedge monitor checks instruction/cmd_count on each cmd_done.
module tb_accel_issue;

  localparam int HOLDOFF = 10;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ext;
  logic [31:0] cpu_instr;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] instruction;
  logic        accel_rst;
  logic [18:0] accel_interrupt;
  logic        accel_done;
  logic [18:0] irq_clr;
  logic [18:0] irq_vec;
  logic        irq;
  logic        busy;
  logic        cmd_done;
  logic [15:0] cmd_count;
  logic        timeout;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_cnt = '0;

  int   lat = 0;
  int   lowcnt = 0;
  int   last_low = 0;
  logic done_m = 1'b0;
  logic kick = 1'b0;
  logic done_hold = 1'b0;

  accel_issue #(
    .DEPTH   (4),
    .HOLDOFF (HOLDOFF),
    .TIMEOUT (50)
  ) dut (
    .clk             (clk),
    .rst_ext         (rst_ext),
    .cpu_instr       (cpu_instr),
    .cpu_valid       (cpu_valid),
    .cpu_ready       (cpu_ready),
    .instruction     (instruction),
    .accel_rst       (accel_rst),
    .accel_interrupt (accel_interrupt),
    .accel_done      (accel_done),
    .irq_clr         (irq_clr),
    .irq_vec         (irq_vec),
    .irq             (irq),
    .busy            (busy),
    .cmd_done        (cmd_done),
    .cmd_count       (cmd_count),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  assign accel_done = done_m | kick | done_hold;

  // Accel model: done in the lat-th cycle after its reset is released.
  always @(negedge clk) begin
    if (!accel_rst) begin
      lowcnt <= lowcnt + 1;
      done_m <= (lat != 0) && (lowcnt + 1 == lat);
    end else begin
      if (lowcnt != 0) last_low <= lowcnt;
      lowcnt <= 0;
      done_m <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin
    if (!rst_ext && cmd_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_cmd_done: got pulse want none (instr %h)",
                 instruction);
      end else begin
        mon_e = sb.pop_front();
        chk("done_instr", instruction, mon_e.instr);
        chk("done_count", {16'h0, cmd_count}, {16'h0, mon_e.cnt});
      end
    end
  end

  task automatic push(input logic [31:0] v, input bit expect_done);
    int n;
    n = 0;
    while (!cpu_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("push_ready");
    if (expect_done) begin
      exp_cnt = exp_cnt + 16'd1;
      sb.push_back('{instr: v, cnt: exp_cnt});
    end
    cpu_instr = v;
    cpu_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail("wait_idle");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_run(input int budget);
    int n;
    n = 0;
    while (accel_rst && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail("wait_run");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] c0;
    int n;
    rst_ext = 1'b1;
    cpu_valid = 1'b0;
    cpu_instr = '0;
    accel_interrupt = '0;
    irq_clr = '0;
    repeat (3) @(negedge clk);
    chk("rst_accel_rst", accel_rst, 1);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_irq_vec", irq_vec, 0);
    chk("rst_irq", irq, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_timeout", timeout, 0);
    rst_ext = 1'b0;
    @(negedge clk);
    chk("ready_post_rst", cpu_ready, 1);

    // single command, 20-cycle accelerator
    lat = 20;
    push(32'hDEADBEEF, 1'b1);
    chk("n0_busy", busy, 0);
    @(negedge clk);
    chk("n1_instr", instruction, 32'hDEADBEEF);
    chk("n1_accel_rst", accel_rst, 1);
    chk("n1_busy", busy, 1);
    @(negedge clk);
    chk("n2_accel_rst", accel_rst, 0);
    wait_idle(400);
    chk("single_low_len", last_low, 20 + HOLDOFF);
    chk("single_count", cmd_count, 1);
    chk("idle_instr_hold", instruction, 32'hDEADBEEF);

    // fill FIFO behind a stalled command
    lat = 0;
    for (int i = 1; i <= 5; i++) push(i, 1'b1);
    chk("full_ready", cpu_ready, 0);
    cpu_instr = 32'h6;
    cpu_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_held", cpu_ready, 0);
    end
    cpu_valid = 1'b0;
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    lat = 20;
    wait_idle(600);
    chk("drained_ready", cpu_ready, 1);
    chk("drained_count", cmd_count, 6);

    // interrupts, then done held high through DRAIN
    lat = 0;
    push(32'hA, 1'b1);
    wait_run(20);
    accel_interrupt = 19'h00005;
    @(negedge clk);
    chk("irq_set_vec", irq_vec, 19'h00005);
    chk("irq_set_irq", irq, 1);
    accel_interrupt = 19'h00001;
    irq_clr = 19'h00001;
    @(negedge clk);
    chk("irq_setwins_vec", irq_vec, 19'h00005);
    chk("irq_setwins_irq", irq, 1);
    accel_interrupt = '0;
    @(negedge clk);
    chk("irq_clr_vec", irq_vec, 19'h00004);
    irq_clr = '0;
    done_hold = 1'b1;
    wait_idle(100);
    done_hold = 1'b0;
    chk("drain_done_count", cmd_count, 7);
    accel_interrupt = 19'h40000;
    @(negedge clk);
    chk("irq_idle_ignored", irq_vec, 19'h00004);
    accel_interrupt = '0;
    irq_clr = 19'h00004;
    @(negedge clk);
    chk("irq_idle_clr_vec", irq_vec, 0);
    chk("irq_idle_clr_irq", irq, 0);
    irq_clr = '0;

    // reset in the middle of RUN with two queued
    push(32'hB1, 1'b1);
    push(32'hB2, 1'b1);
    push(32'hB3, 1'b1);
    wait_run(20);
    accel_interrupt = 19'h00003;
    @(negedge clk);
    accel_interrupt = '0;
    chk("pre_rst_vec", irq_vec, 19'h00003);
    rst_ext = 1'b1;
    #1;
    chk("mid_rst_accel_rst", accel_rst, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_irq_vec", irq_vec, 0);
    chk("mid_rst_ready", cpu_ready, 0);
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst_ext = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_empty_busy", busy, 0);
    chk("post_rst_accel_rst", accel_rst, 1);
    chk("post_rst_count", cmd_count, 0);

    lat = 20;
    push(32'h00C0FFEE, 1'b1);
    wait_idle(400);
    chk("recover_count", cmd_count, 1);

`ifdef ACCEL_ISSUE_TIMEOUT_EN
    lat = 0;
    c0 = exp_cnt;
    push(32'h70, 1'b0);
    push(32'h71, 1'b1);
    n = 0;
    while (!timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("wait_timeout");
    lat = 20;
    chk("to_busy", busy, 0);
    chk("to_count", cmd_count, c0);
    @(negedge clk);
    chk("to_run_len", last_low, 50);
    wait_idle(400);
    chk("to_sticky", timeout, 1);
    chk("to_next_count", cmd_count, c0 + 16'd1);
`else
    c0 = exp_cnt;
    n = 0;
    chk("timeout_tied", timeout, 0);
    chk("final_count", cmd_count, c0 + 16'(n));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accel_issue.md
# accel_issue

Command issuer directly upstream of `Accel`. It buffers 32-bit accelerator instructions from the CPU and presents them one at a time on `Accel`'s `instruction` input. Each command is started by pulsing the accelerator's reset, and completion is detected from `accel_done` plus a fixed holdoff, because `accel_done` rises before the last result has propagated. It also collects `accel_interrupt` bits into a sticky, CPU-clearable vector.

## Interface
Parameters:
- `DEPTH`, 4: instruction FIFO entries; must be a power of 2, ≥2.
- `HOLDOFF`, 10: cycles waited after `accel_done` before a command is complete; must be ≥1.
- `TIMEOUT`, 4096: watchdog limit in cycles; used only with `ACCEL_ISSUE_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_ext`  in  1  asynchronous, active-high reset.
- `cpu_instr`  in  32  instruction from CPU.
- `cpu_valid`  in  1  `cpu_instr` valid.
- `cpu_ready`  out  1  FIFO can accept; push occurs when `cpu_valid && cpu_ready`.
- `instruction`  out  32  to `Accel.instruction`; held stable for the whole command.
- `accel_rst`  out  1  to `Accel.rst_ext`.
- `accel_interrupt`  in  19  from `Accel`.
- `accel_done`  in  1  from `Accel`.
- `irq_clr`  in  19  write-1-to-clear mask for `irq_vec`.
- `irq_vec`  out  19  sticky interrupt bits.
- `irq`  out  1  `|irq_vec`.
- `busy`  out  1  high in any state other than IDLE.
- `cmd_done`  out  1  one-cycle pulse per completed command.
- `cmd_count`  out  16  count of completed commands; wraps from 0xFFFF to 0.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- **Reset values:**
  - `accel_rst`=1; all other outputs 0.
  - `cpu_ready`=0 while `rst_ext` is high.
  - FIFO empty, state IDLE.
- **FIFO:**
  - `cpu_ready` = !full.
  - Pop happens only on the IDLE→LOAD transition.
  - The FIFO does not push when full, and there is no bypass path.
  - A push and a pop in the same cycle are both honoured.
- **FSM states and transitions:**
  - IDLE: `accel_rst`=1. If the FIFO is non-empty, pop into the `instruction` register and go to LOAD.
  - LOAD: `accel_rst`=1 for exactly one cycle, then go to RUN.
  - RUN: `accel_rst`=0. When `accel_done`=1, load the holdoff counter with HOLDOFF−1 and go to DRAIN.
  - DRAIN: `accel_rst`=0. Decrement the counter each cycle. At 0: pulse `cmd_done`, increment `cmd_count`, go to IDLE.
- **Interrupts:**
  - In RUN and DRAIN: `irq_vec` ← (`irq_vec` & ~`irq_clr`) | `accel_interrupt`. Set wins over a simultaneous clear of the same bit.
  - In other states, `accel_interrupt` is ignored; `irq_clr` still applies.
- `accel_done` is ignored outside RUN, so stray or held `done` in DRAIN has no effect.
- `instruction` keeps its last value in IDLE and changes only on a pop.
- **`rst_ext` mid-command:** the FSM, FIFO contents, `irq_vec` and `timeout` are all discarded immediately; `accel_rst` goes to 1 asynchronously.

## Timing
- Push at edge N into an empty FIFO in IDLE:
  - `instruction` updated and state LOAD after edge N+1.
  - RUN after edge N+2, so `Accel` sees reset released from cycle N+2.
- `accel_done` sampled high at edge M: `cmd_done` is high during cycle M+HOLDOFF.
- Back-to-back commands: IDLE lasts exactly one cycle between a `cmd_done` and the next LOAD. `accel_rst` is therefore high for 2 cycles (IDLE + LOAD) between commands.
- `cpu_ready` reflects the FIFO occupancy registered at the previous edge (no combinational path from `cpu_valid`).
- `irq` is registered together with `irq_vec`: it is high in the cycle after the setting edge.

## Configuration
- **`ACCEL_ISSUE_TIMEOUT_EN` defined:**
  - A cycle counter runs in RUN and is cleared on entry to RUN.
  - Reaching TIMEOUT cycles without `accel_done` sets `timeout`=1 (sticky until `rst_ext`), forces IDLE, and does not pulse `cmd_done` or increment `cmd_count`.
  - The next queued command then proceeds normally.
- **Not defined:** RUN waits indefinitely, `timeout` is tied to 0, and no counter logic is generated.

## Structure
- Package `accel_issue_pkg` holds:
  - the FSM state enum (IDLE, LOAD, RUN, DRAIN);
  - `INSTR_W`=32, `IRQ_W`=19, `CNT_W`=16.
- Sub-module `accel_issue_fifo` is a synchronous FIFO, parameterised by DEPTH and width, with full/empty flags. The FSM, holdoff and watchdog logic live in the top module.

## Test plan
- **Single command:** push 0xDEADBEEF after reset; `Accel` model raises `accel_done` 20 cycles after `accel_rst` falls. Expect:
  - `instruction`=0xDEADBEEF;
  - `accel_rst` low for 20+HOLDOFF cycles;
  - one `cmd_done` pulse; `cmd_count`=1.
- **Full FIFO:** push 5 commands (0x1–0x5) with the accelerator stalled. Expect `cpu_ready`=0 after the 5th accepted push (1 in flight + 4 queued). The 6th push is held off, and commands then issue in order 0x1…0x5.
- **Interrupts:** `accel_interrupt`=0x00005 in RUN, and `irq_clr`=0x00001 in the same cycle that bit 0 is re-asserted. Expect `irq_vec`=0x00005 and `irq`=1. A clear with no re-assert gives `irq_vec`=0x00004.
- **Done ignored in DRAIN:** hold `accel_done` high through DRAIN. Expect exactly one `cmd_done`, and `cmd_count` increments by 1.
- **Reset mid-command:** assert `rst_ext` mid-RUN with 2 commands queued. Expect, asynchronously, `accel_rst`=1, `busy`=0, `irq_vec`=0, and FIFO empty after release.
- **With `ACCEL_ISSUE_TIMEOUT_EN` and TIMEOUT=50:** never raise `accel_done`. Expect `timeout`=1 after 50 RUN cycles, a return to IDLE, `cmd_count` unchanged, and the next command issued.
